hls_main_mul_mac_pipe: RTL and testbench

//  Pipelined unsigned x signed multiplier/accumulator for the hls_main tracking datapath: a pixel/weight (unsigned) times coefficient (signed).

---
 rtl/hls_main_mul_pkg.sv | 35 +++
 rtl/hls_main_mul_mac_limit.sv | 47 ++++
 rtl/hls_main_mul_mac_pipe.sv | 135 +++++++++++++
 tb/tb_hls_main_mul_mac_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_main_mul_pkg.sv
// Shared widths, rounding/saturation constants and stage-record layout for the
// hls_main unsigned x signed multiply-accumulate pipeline.
package hls_main_mul_pkg;

    // Stage-1 record, LSB first: valid, in_last, in_acc, din1, din0
    localparam int REC_VALID    = 0;
    localparam int REC_LAST     = 1;
    localparam int REC_ACC      = 2;
    localparam int REC_DIN1_LSB = 3;

    function automatic int rec_width(input int w0, input int w1);
        return w0 + w1 + 3;
    endfunction

    // Unsigned operand gains a zero sign bit before the signed multiply.
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 1;
    endfunction

    function automatic longint round_const(input int shift);
        if (shift > 0)
            return 64'sd1 <<< (shift - 1);
        else
            return 64'sd0;
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/hls_main_mul_mac_limit.sv
// Combinational round-half-up, arithmetic shift and output limiting.
// HLS_MAIN_MUL_SAT_EN selects clamping with overflow flag; otherwise two's-complement wrap.
module hls_main_mul_mac_limit
    import hls_main_mul_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int DOUT_WIDTH = 16,
    parameter int SHIFT      = 0
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    output logic [DOUT_WIDTH-1:0] dout_o,
    output logic                  ovf_o
);
    // One extra bit keeps the rounding add from wrapping.
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] RND = RW'(round_const(SHIFT));

    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] r;

    assign sum = RW'($signed(acc_i)) + RND;
    assign r   = sum >>> SHIFT;

`ifdef HLS_MAIN_MUL_SAT_EN
    localparam logic signed [RW-1:0] MAXV = RW'(sat_max(DOUT_WIDTH));
    localparam logic signed [RW-1:0] MINV = RW'(sat_min(DOUT_WIDTH));

    always_comb begin
        dout_o = r[DOUT_WIDTH-1:0];
        ovf_o  = 1'b0;
        if (r > MAXV) begin
            dout_o = MAXV[DOUT_WIDTH-1:0];
            ovf_o  = 1'b1;
        end else if (r < MINV) begin
            dout_o = MINV[DOUT_WIDTH-1:0];
            ovf_o  = 1'b1;
        end
    end
`else
    logic unused_r_hi;

    assign dout_o      = r[DOUT_WIDTH-1:0];
    assign ovf_o       = 1'b0;
    assign unused_r_hi = ^r[RW-1:DOUT_WIDTH];
`endif

endmodule

// File: rtl/hls_main_mul_mac_pipe.sv
// Pipelined unsigned x signed multiply-accumulate with valid/ready flow control.
// Optional output saturation is enabled by defining HLS_MAIN_MUL_SAT_EN.
module hls_main_mul_mac_pipe
    import hls_main_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 0,
    parameter int NUM_STAGE  = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  in_acc,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_ovf
);
    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int RW = rec_width(DIN0_WIDTH, DIN1_WIDTH);

    // Handshake: a beat moves when in_valid && in_ready; the whole pipe advances
    // together whenever the output register is empty or being consumed, so
    // in_ready mirrors that advance and a stalled output freezes every stage.
    logic advance;
    logic out_valid_q;
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    logic [RW-1:0] s1_q;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            s1_q <= '0;
        else if (advance)
            s1_q <= {din0, din1, in_acc, in_last, in_valid};
    end

    logic signed [PW-1:0] s1_prod;
    logic [DIN0_WIDTH-1:0] s1_din0;
    logic [DIN1_WIDTH-1:0] s1_din1;
    assign s1_din0 = s1_q[RW-1 -: DIN0_WIDTH];
    assign s1_din1 = s1_q[REC_DIN1_LSB +: DIN1_WIDTH];
    assign s1_prod = PW'($signed({1'b0, s1_din0})) * PW'($signed(s1_din1));

    logic signed [PW-1:0] fin_p;
    logic                 fin_valid;
    logic                 fin_acc;
    logic                 fin_last;

    generate
        if (NUM_STAGE > 2) begin : g_prod_pipe
            // Product stages exist so synthesis can retime the multiply into them.
            logic signed [PW-1:0] pp_q [NUM_STAGE-2];
            logic [2:0]           pf_q [NUM_STAGE-2];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int i = 0; i < NUM_STAGE - 2; i++) begin
                        pp_q[i] <= '0;
                        pf_q[i] <= '0;
                    end
                end else if (advance) begin
                    pp_q[0] <= s1_prod;
                    pf_q[0] <= {s1_q[REC_ACC], s1_q[REC_LAST], s1_q[REC_VALID]};
                    for (int i = 1; i < NUM_STAGE - 2; i++) begin
                        pp_q[i] <= pp_q[i-1];
                        pf_q[i] <= pf_q[i-1];
                    end
                end
            end

            assign fin_p     = pp_q[NUM_STAGE-3];
            assign fin_valid = pf_q[NUM_STAGE-3][0];
            assign fin_last  = pf_q[NUM_STAGE-3][1];
            assign fin_acc   = pf_q[NUM_STAGE-3][2];
        end else begin : g_prod_comb
            assign fin_p     = s1_prod;
            assign fin_valid = s1_q[REC_VALID];
            assign fin_last  = s1_q[REC_LAST];
            assign fin_acc   = s1_q[REC_ACC];
        end
    endgenerate

    logic [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]  acc_d;
    logic [ACC_WIDTH-1:0]  p_ext;
    logic [DOUT_WIDTH-1:0] lim_dout;
    logic                  lim_ovf;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  ovf_q;

    assign p_ext = ACC_WIDTH'(fin_p);
    assign acc_d = fin_acc ? acc_q + p_ext : p_ext;

    hls_main_mul_mac_limit #(
        .ACC_WIDTH (ACC_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_limit (
        .acc_i (acc_d),
        .dout_o(lim_dout),
        .ovf_o (lim_ovf)
    );

    // Non-last beats update acc silently; dout keeps the last emitted result.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= fin_valid && fin_last;
            if (fin_valid) begin
                acc_q <= acc_d;
                if (fin_last) begin
                    dout_q <= lim_dout;
                    ovf_q  <= lim_ovf;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_hls_main_mul_mac_pipe.sv
// Directed bench for hls_main_mul_mac_pipe: default instance plus a SHIFT=4 instance
// on shared inputs, checked against a behavioural accumulate model and hand literals.
module tb_hls_main_mul_mac_pipe;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_acc = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  din0 = '0;
  logic [15:0] din1 = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] dout;
  logic        in_ready_s4, out_valid_s4, out_ovf_s4;
  logic [15:0] dout_s4;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_lo = 0;
  int stall_hi = 0;
  int out_cnt = 0;
  int stall_seen = 0;

  logic signed [31:0] acc_m;
  logic [16:0] exp_q[$];
  logic [16:0] exp4_q[$];

  hls_main_mul_mac_pipe u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_ovf(out_ovf)
  );

  hls_main_mul_mac_pipe #(.SHIFT(4)) u_dut_s4 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_s4),
    .din0(din0), .din1(din1), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid_s4), .out_ready(out_ready), .dout(dout_s4), .out_ovf(out_ovf_s4)
  );

  // clock / reset-independent housekeeping
  always #5 ap_clk = ~ap_clk;

  initial forever begin
    @(posedge ap_clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge ap_clk);
    #1 out_ready = !(cyc >= stall_lo && cyc < stall_hi);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // model: arithmetic on the specification's rules, {ovf, dout}
  function automatic logic [16:0] exp_out(input logic signed [31:0] a, input int sh);
    longint r;
    r = longint'(a);
    if (sh > 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
`ifdef HLS_MAIN_MUL_SAT_EN
    if (r > 32767) return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, r[15:0]};
  endfunction

  initial forever begin
    @(posedge ap_clk or negedge ap_rst_n);
    if (!ap_rst_n) begin
      acc_m = '0;
      exp_q.delete();
      exp4_q.delete();
    end else if (in_valid && in_ready) begin
      longint p;
      p = longint'(din0) * longint'($signed(din1));
      acc_m = in_acc ? acc_m + 32'(p) : 32'(p);
      if (in_last) begin
        exp_q.push_back(exp_out(acc_m, 0));
        exp4_q.push_back(exp_out(acc_m, 4));
      end
    end
  end

  // scoreboard / compare process
  initial begin
    logic        hold_pending;
    logic [15:0] held_dout;
    logic [16:0] e;
    hold_pending = 1'b0;
    held_dout = '0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        hold_pending = 1'b0;
      end else begin
        check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        check("s4_valid", 32'(out_valid_s4), 32'(out_valid));
        if (!out_ready && !in_ready) stall_seen++;
        if (hold_pending) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_dout", 32'(dout), 32'(held_dout));
        end
        hold_pending = out_valid && !out_ready;
        held_dout = dout;
        if (out_valid && out_ready) begin
          out_cnt++;
          if (exp_q.size() == 0 || exp4_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_out: got dout 0x%0h with no result pending", dout);
          end else begin
            e = exp_q.pop_front();
            check("dout", 32'(dout), 32'(e[15:0]));
            check("ovf", 32'(out_ovf), 32'(e[16]));
            e = exp4_q.pop_front();
            check("dout_s4", 32'(dout_s4), 32'(e[15:0]));
            check("ovf_s4", 32'(out_ovf_s4), 32'(e[16]));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] a, input logic [15:0] b, input logic acc, input logic last);
    bit ok;
    ok = 1'b0;
    @(negedge ap_clk);
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    in_acc = acc;
    in_last = last;
    for (int i = 0; i < 50; i++) begin
      @(posedge ap_clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: beat din0=%0d not taken in 50 cycles", a);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ap_clk);
      in_valid = 1'b0;
      n++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      n_vec++;
      n_fail++;
      $display("FAIL out_timeout: out_valid not seen within 30 cycles");
    end
  endtask

  task automatic idle(input int n);
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (n) @(posedge ap_clk);
  endtask

  initial begin
    int n;
    int c0;

    // reset state
    repeat (2) @(negedge ap_clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // single product, latency
    send(8'd200, -16'sd100, 1'b0, 1'b1);
    wait_out(n);
    check("t1_latency", 32'(n), 32'd3);
    check("t1_dout", 32'(dout), 32'h0000B1E0);
    check("t1_ovf", 32'(out_ovf), 32'd0);
    check("t1_dout_s4", 32'(dout_s4), 32'h0000FB1E);

    // out-of-range result
    send(8'd3, 16'sd20000, 1'b0, 1'b1);
    wait_out(n);
`ifdef HLS_MAIN_MUL_SAT_EN
    check("t2_dout", 32'(dout), 32'h00007FFF);
    check("t2_ovf", 32'(out_ovf), 32'd1);
`else
    check("t2_dout", 32'(dout), 32'h0000EA60);
    check("t2_ovf", 32'(out_ovf), 32'd0);
`endif
    check("t2_dout_s4", 32'(dout_s4), 32'h00000EA6);

    // three-beat accumulation, one output
    c0 = out_cnt;
    send(8'd10, 16'sd100, 1'b0, 1'b0);
    send(8'd20, -16'sd50, 1'b1, 1'b0);
    send(8'd5, 16'sd7, 1'b1, 1'b1);
    wait_out(n);
    check("t3_dout", 32'(dout), 32'd35);
    check("t3_dout_s4", 32'(dout_s4), 32'd2);
    idle(4);
    check("t3_out_count", 32'(out_cnt - c0), 32'd1);

    // rounding with SHIFT=4
    send(8'd1, 16'sd24, 1'b0, 1'b1);
    wait_out(n);
    check("t5a_dout", 32'(dout), 32'h00000018);
    check("t5a_dout_s4", 32'(dout_s4), 32'd2);
    send(8'd1, -16'sd24, 1'b0, 1'b1);
    wait_out(n);
    check("t5b_dout", 32'(dout), 32'h0000FFE8);
    check("t5b_dout_s4", 32'(dout_s4), 32'h0000FFFF);
    send(8'd1, 16'sd8, 1'b0, 1'b1);
    wait_out(n);
    check("t5c_dout", 32'(dout), 32'd8);
    check("t5c_dout_s4", 32'(dout_s4), 32'd1);
    idle(2);

    // streaming with a 5-cycle downstream stall
    c0 = out_cnt;
    stall_seen = 0;
    stall_lo = cyc + 5;
    stall_hi = stall_lo + 5;
    for (int i = 0; i < 8; i++)
      send(8'(i * 13 + 1), 16'(i * 300 - 1000), 1'b0, 1'b1);
    idle(20);
    check("t4_out_count", 32'(out_cnt - c0), 32'd8);
    check("t4_stall_cycles", 32'(stall_seen), 32'd5);

    // reset with beats in flight
    send(8'd7, 16'sd9, 1'b0, 1'b0);
    send(8'd11, 16'sd13, 1'b1, 1'b0);
    @(negedge ap_clk);
    in_valid = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_dout", 32'(dout), 32'd0);
    check("t6_rst_dout_s4", 32'(dout_s4), 32'd0);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    send(8'd2, 16'sd3, 1'b1, 1'b1);
    wait_out(n);
    check("t6_dout", 32'(dout), 32'd6);
    check("t6_dout_s4", 32'(dout_s4), 32'd0);
    idle(6);

    check("pending_results", 32'(exp_q.size()), 32'd0);
    check("pending_results_s4", 32'(exp4_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end

endmodule
